// File: rtl/result_stage_pipe.sv
// Per-pipe result shift pipeline: carries issued instructions through DEPTH stages,
// captures unit results, and drives RF write-back. Optional checker: RESULT_PIPE_CHECK_EN.
module result_stage_pipe #(
  parameter int DEPTH       = 7,
  parameter int DATA_W      = 128,
  parameter int ADDR_W      = 7,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  issue_valid,
  input  logic [2:0]                            issue_unit_id,
  input  logic [ADDR_W-1:0]                     issue_reg_dst,
  input  logic                                  issue_reg_wr,
  input  logic [3:0]                            issue_latency,
  input  logic                                  cmpl_valid,
  input  logic [2:0]                            cmpl_stage,
  input  logic [DATA_W-1:0]                     cmpl_data,
  input  logic                                  flush,
  output logic [(DATA_W+ADDR_W+8)*DEPTH-1:0]    packed_stages,
  output logic                                  wb_en,
  output logic [ADDR_W-1:0]                     wb_addr,
  output logic [DATA_W-1:0]                     wb_data,
  output logic                                  err_incomplete
);

  localparam int PW = DATA_W + ADDR_W + 8;

  // Stage state, index 1 = youngest, DEPTH = retiring
  logic [DEPTH:1]    valid_r, ready_r, wr_r;
  logic [2:0]        unit_r [1:DEPTH];
  logic [ADDR_W-1:0] dst_r  [1:DEPTH];
  logic [3:0]        lat_r  [1:DEPTH];
  logic [DATA_W-1:0] res_r  [1:DEPTH];

  // Entry about to move into each stage, before kill/completion
  logic [DEPTH:1]    src_valid_s, src_ready_s, src_wr_s;
  logic [2:0]        src_unit_s [1:DEPTH];
  logic [ADDR_W-1:0] src_dst_s  [1:DEPTH];
  logic [3:0]        src_lat_s  [1:DEPTH];
  logic [DATA_W-1:0] src_res_s  [1:DEPTH];

  logic [DEPTH:1]    kill_s, hit_s;
  logic [DEPTH:1]    nxt_valid_s, nxt_ready_s, nxt_wr_s;
  logic [2:0]        nxt_unit_s [1:DEPTH];
  logic [ADDR_W-1:0] nxt_dst_s  [1:DEPTH];
  logic [3:0]        nxt_lat_s  [1:DEPTH];
  logic [DATA_W-1:0] nxt_res_s  [1:DEPTH];

  function automatic logic [PW-1:0] pack_entry(
    input logic              valid,
    input logic              ready,
    input logic              wr,
    input logic [2:0]        unit,
    input logic [DATA_W-1:0] res,
    input logic [ADDR_W-1:0] dst,
    input logic [3:0]        lat
  );
    logic [PW-1:0] word;
    if (valid) begin
      word = {unit, res, dst, wr & ready, lat};
    end else begin
      word = {PW{1'b0}};
    end
    return word;
  endfunction

  // Select the entry moving into each stage: issue for stage 1, predecessor otherwise
  always_comb begin
    if (issue_valid) begin
      src_valid_s[1] = 1'b1;
      src_ready_s[1] = 1'b0;
      src_wr_s[1]    = issue_reg_wr;
      src_unit_s[1]  = issue_unit_id;
      src_dst_s[1]   = issue_reg_dst;
      src_lat_s[1]   = issue_latency;
      src_res_s[1]   = {DATA_W{1'b0}};
    end else begin
      src_valid_s[1] = 1'b0;
      src_ready_s[1] = 1'b0;
      src_wr_s[1]    = 1'b0;
      src_unit_s[1]  = 3'd0;
      src_dst_s[1]   = {ADDR_W{1'b0}};
      src_lat_s[1]   = 4'd0;
      src_res_s[1]   = {DATA_W{1'b0}};
    end
    for (int s = 2; s <= DEPTH; s++) begin
      src_valid_s[s] = valid_r[s-1];
      src_ready_s[s] = ready_r[s-1];
      src_wr_s[s]    = wr_r[s-1];
      src_unit_s[s]  = unit_r[s-1];
      src_dst_s[s]   = dst_r[s-1];
      src_lat_s[s]   = lat_r[s-1];
      src_res_s[s]   = res_r[s-1];
    end
  end

  // Flush kill and completion targeting; a killed entry ignores its completion
  always_comb begin
    for (int s = 1; s <= DEPTH; s++) begin
      kill_s[s] = flush && (s <= FLUSH_DEPTH);
      hit_s[s]  = cmpl_valid && src_valid_s[s] && ((int'(cmpl_stage) + 1) == s);
    end
  end

  // Next-state per stage: kill wins, then completion, else plain shift
  always_comb begin
    for (int s = 1; s <= DEPTH; s++) begin
      if (kill_s[s]) begin
        nxt_valid_s[s] = 1'b0;
        nxt_ready_s[s] = 1'b0;
        nxt_wr_s[s]    = 1'b0;
        nxt_unit_s[s]  = 3'd0;
        nxt_dst_s[s]   = {ADDR_W{1'b0}};
        nxt_lat_s[s]   = 4'd0;
        nxt_res_s[s]   = {DATA_W{1'b0}};
      end else if (hit_s[s]) begin
        nxt_valid_s[s] = src_valid_s[s];
        nxt_ready_s[s] = 1'b1;
        nxt_wr_s[s]    = src_wr_s[s];
        nxt_unit_s[s]  = src_unit_s[s];
        nxt_dst_s[s]   = src_dst_s[s];
        nxt_lat_s[s]   = src_lat_s[s];
        nxt_res_s[s]   = cmpl_data;
      end else begin
        nxt_valid_s[s] = src_valid_s[s];
        nxt_ready_s[s] = src_ready_s[s];
        nxt_wr_s[s]    = src_wr_s[s];
        nxt_unit_s[s]  = src_unit_s[s];
        nxt_dst_s[s]   = src_dst_s[s];
        nxt_lat_s[s]   = src_lat_s[s];
        nxt_res_s[s]   = src_res_s[s];
      end
    end
  end

  // Stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= {DEPTH{1'b0}};
      ready_r <= {DEPTH{1'b0}};
      wr_r    <= {DEPTH{1'b0}};
      for (int s = 1; s <= DEPTH; s++) begin
        unit_r[s] <= 3'd0;
        dst_r[s]  <= {ADDR_W{1'b0}};
        lat_r[s]  <= 4'd0;
        res_r[s]  <= {DATA_W{1'b0}};
      end
    end else begin
      valid_r <= nxt_valid_s;
      ready_r <= nxt_ready_s;
      wr_r    <= nxt_wr_s;
      for (int s = 1; s <= DEPTH; s++) begin
        unit_r[s] <= nxt_unit_s[s];
        dst_r[s]  <= nxt_dst_s[s];
        lat_r[s]  <= nxt_lat_s[s];
        res_r[s]  <= nxt_res_s[s];
      end
    end
  end

  // Packed view of every stage for the forwarding network
  always_comb begin
    packed_stages = {(PW*DEPTH){1'b0}};
    for (int s = 1; s <= DEPTH; s++) begin
      packed_stages[(s-1)*PW +: PW] = pack_entry(valid_r[s], ready_r[s], wr_r[s],
                                                 unit_r[s], res_r[s], dst_r[s], lat_r[s]);
    end
  end

  assign wb_en   = valid_r[DEPTH] & wr_r[DEPTH] & ready_r[DEPTH];
  assign wb_addr = dst_r[DEPTH];
  assign wb_data = res_r[DEPTH];

`ifdef RESULT_PIPE_CHECK_EN
  logic err_r;
  logic lat_err_s;
  logic retire_bad_s;

  // A completion stage that disagrees with the unit's declared latency
  always_comb begin
    lat_err_s = 1'b0;
    for (int s = 1; s <= DEPTH; s++) begin
      if (hit_s[s] && !kill_s[s]) begin
        lat_err_s = lat_err_s | (src_lat_s[s] != ({1'b0, cmpl_stage} + 4'd1));
      end else begin
        lat_err_s = lat_err_s;
      end
    end
  end

  assign retire_bad_s = valid_r[DEPTH] & wr_r[DEPTH] & ~ready_r[DEPTH];

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (retire_bad_s || lat_err_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err_incomplete = err_r;
`else
  assign err_incomplete = 1'b0;
`endif

endmodule

// File: tb/tb_result_stage_pipe.sv
// Scoreboard bench for result_stage_pipe: expected write-backs queued at issue,
// popped and compared when due; packed stage words checked at key points.
module tb_result_stage_pipe;

  localparam int DEPTH  = 7;
  localparam int DATA_W = 128;
  localparam int ADDR_W = 7;
  localparam int PW     = 143;

  logic                   clk;
  logic                   rst;
  logic                   issue_valid;
  logic [2:0]             issue_unit_id;
  logic [ADDR_W-1:0]      issue_reg_dst;
  logic                   issue_reg_wr;
  logic [3:0]             issue_latency;
  logic                   cmpl_valid;
  logic [2:0]             cmpl_stage;
  logic [DATA_W-1:0]      cmpl_data;
  logic                   flush;
  logic [PW*DEPTH-1:0]    packed_stages;
  logic                   wb_en;
  logic [ADDR_W-1:0]      wb_addr;
  logic [DATA_W-1:0]      wb_data;
  logic                   err_incomplete;

  result_stage_pipe #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FLUSH_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_unit_id(issue_unit_id), .issue_reg_dst(issue_reg_dst),
    .issue_reg_wr(issue_reg_wr), .issue_latency(issue_latency),
    .cmpl_valid(cmpl_valid), .cmpl_stage(cmpl_stage), .cmpl_data(cmpl_data),
    .flush(flush), .packed_stages(packed_stages),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .err_incomplete(err_incomplete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                due;
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_t;

  wb_t sb[$];
  int  cyc;
  int  n_vec;
  int  n_err;
  logic exp_err;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [2:0] u, input logic [127:0] r,
                                       input logic [6:0] d, input logic e, input logic [3:0] l);
    return {u, r, d, e, l};
  endfunction

  function automatic logic [PW-1:0] stg(input int s);
    return packed_stages[(s-1)*PW +: PW];
  endfunction

  task automatic idle();
    issue_valid   = 1'b0;
    issue_unit_id = 3'd0;
    issue_reg_dst = 7'd0;
    issue_reg_wr  = 1'b0;
    issue_latency = 4'd0;
    cmpl_valid    = 1'b0;
    cmpl_stage    = 3'd0;
    cmpl_data     = 128'd0;
    flush         = 1'b0;
  endtask

  task automatic drive_issue(input logic [2:0] u, input logic [6:0] rd, input logic wr,
                             input logic [3:0] lat, input logic ex_en, input logic [127:0] ex_data);
    issue_valid   = 1'b1;
    issue_unit_id = u;
    issue_reg_dst = rd;
    issue_reg_wr  = wr;
    issue_latency = lat;
    sb.push_back('{due: cyc + DEPTH, en: ex_en, addr: rd, data: ex_data});
  endtask

  task automatic drive_cmpl(input logic [2:0] k, input logic [127:0] d);
    cmpl_valid = 1'b1;
    cmpl_stage = k;
    cmpl_data  = d;
  endtask

  task automatic step();
    wb_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("wb_en", {159'd0, wb_en}, {159'd0, e.en});
      if (e.en) begin
        check("wb_addr", {153'd0, wb_addr}, {153'd0, e.addr});
        check("wb_data", {32'd0, wb_data}, {32'd0, e.data});
      end
    end else begin
      check("wb_idle", {159'd0, wb_en}, 160'd0);
    end
    idle();
  endtask

  logic [127:0] a5;
  logic [127:0] d;

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    exp_err = 1'b0;
    a5 = {16{8'hA5}};
    idle();
    rst = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_packed", {159'd0, (packed_stages == '0)}, 160'd1);
    check("rst_wb_en", {159'd0, wb_en}, 160'd0);
    check("rst_err", {159'd0, err_incomplete}, 160'd0);
    rst = 1'b0;

    // Latency 1, completion on issue
    drive_issue(3'd2, 7'd5, 1'b1, 4'd1, 1'b1, a5);
    drive_cmpl(3'd0, a5);
    step();
    check("a_stage1", stg(1), mk(3'd2, a5, 7'd5, 1'b1, 4'd1));
    for (int i = 0; i < DEPTH - 1; i++) step();
    check("a_stage7", stg(7), mk(3'd2, a5, 7'd5, 1'b1, 4'd1));
    step();

    // Latency 4, completion at k=3, then overwrite at k=5
    drive_issue(3'd3, 7'd9, 1'b1, 4'd4, 1'b1, 128'h5678);
    step();
    check("b_stage1", stg(1), mk(3'd3, 128'd0, 7'd9, 1'b0, 4'd4));
    step();
    step();
    check("b_stage3", stg(3), mk(3'd3, 128'd0, 7'd9, 1'b0, 4'd4));
    drive_cmpl(3'd3, 128'h1234);
    step();
    check("b_stage4", stg(4), mk(3'd3, 128'h1234, 7'd9, 1'b1, 4'd4));
    step();
    check("b_stage5", stg(5), mk(3'd3, 128'h1234, 7'd9, 1'b1, 4'd4));
    drive_cmpl(3'd5, 128'h5678);
    step();
    check("b_overwrite", stg(6), mk(3'd3, 128'h5678, 7'd9, 1'b1, 4'd4));
`ifdef RESULT_PIPE_CHECK_EN
    exp_err = 1'b1;
`endif
    step();

    // Back-to-back issue rd=1..7
    for (int i = 1; i <= 7; i++) begin
      d = {96'd0, 32'(i) * 32'h1111_1111};
      drive_issue(3'd1, 7'(i), 1'b1, 4'd1, 1'b1, d);
      drive_cmpl(3'd0, d);
      step();
    end
    for (int i = 0; i < DEPTH; i++) step();

    // Flush kills the issuing entry and the one moving into stage 2
    drive_issue(3'd1, 7'd12, 1'b1, 4'd1, 1'b1, 128'hC12);
    drive_cmpl(3'd0, 128'hC12);
    step();
    drive_issue(3'd1, 7'd11, 1'b1, 4'd1, 1'b0, 128'hC11);
    drive_cmpl(3'd0, 128'hC11);
    step();
    drive_issue(3'd1, 7'd10, 1'b1, 4'd1, 1'b0, 128'hC10);
    drive_cmpl(3'd0, 128'hC10);
    flush = 1'b1;
    step();
    check("f_stage1", stg(1), 143'd0);
    check("f_stage2", stg(2), 143'd0);
    check("f_stage3", stg(3), mk(3'd1, 128'hC12, 7'd12, 1'b1, 4'd1));
    for (int i = 0; i < DEPTH; i++) step();

    // Completions to a bubble and to k >= DEPTH are ignored
    drive_issue(3'd4, 7'd20, 1'b1, 4'd1, 1'b0, 128'd0);
    for (int i = 0; i < 5; i++) step();
    drive_cmpl(3'd1, 128'hBAD1);
    step();
    check("bubble_cmpl", stg(2), 143'd0);
    drive_cmpl(3'd7, 128'hBAD7);
    step();
    check("k_ge_depth", stg(7), mk(3'd4, 128'd0, 7'd20, 1'b0, 4'd1));
`ifdef RESULT_PIPE_CHECK_EN
    exp_err = 1'b1;
`endif
    step();
    check("err_mid", {159'd0, err_incomplete}, {159'd0, exp_err});

    // Asynchronous reset with entries in flight
    for (int i = 0; i < 4; i++) begin
      d = {96'd0, 32'(i + 40)};
      drive_issue(3'd5, 7'(i + 40), 1'b1, 4'd1, 1'b1, d);
      drive_cmpl(3'd0, d);
      step();
    end
    rst = 1'b1;
    #1;
    check("arst_packed", {159'd0, (packed_stages == '0)}, 160'd1);
    check("arst_wb_en", {159'd0, wb_en}, 160'd0);
    check("arst_err", {159'd0, err_incomplete}, 160'd0);
    sb.delete();
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) step();
    check("post_rst_packed", {159'd0, (packed_stages == '0)}, 160'd1);

    // Write without completion: no write-back, checker flags it
    exp_err = 1'b0;
    drive_issue(3'd6, 7'd3, 1'b1, 4'd3, 1'b0, 128'd0);
    for (int i = 0; i < DEPTH; i++) step();
    check("inc_stage7", stg(7), mk(3'd6, 128'd0, 7'd3, 1'b0, 4'd3));
    check("inc_err_pre", {159'd0, err_incomplete}, 160'd0);
    step();
`ifdef RESULT_PIPE_CHECK_EN
    exp_err = 1'b1;
`endif
    check("inc_err", {159'd0, err_incomplete}, {159'd0, exp_err});
    step();
    step();
    check("inc_err_sticky", {159'd0, err_incomplete}, {159'd0, exp_err});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
